// File: rtl/maze_wall_follower_if.sv
// Cell-memory port between the wall follower (master) and the 64x64 maze store (slave).
interface maze_wall_follower_if;
    logic [5:0] row;
    logic [5:0] col;
    logic       oe;
    logic       we;
    logic       maze_in;

    // No backpressure: oe is a one-cycle read request whose cell bit 0 appears on
    // maze_in the following cycle; we is a one-cycle path-mark write of cell[row][col].
    // The store accepts every strobe; oe and we are never high together.
    modport master (output row, col, oe, we, input maze_in);
    modport slave  (input row, col, oe, we, output maze_in);
endinterface

// File: rtl/maze_wall_follower.sv
// Right-hand-rule maze walker: probes neighbours through the cell-memory port,
// marks each entered cell, and stops on a border exit (done) or when trapped (stuck).
module maze_wall_follower #(
    parameter logic [15:0] MAX_STEPS = 16'hFFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [5:0]                  starting_row_i,
    input  logic [5:0]                  starting_col_i,
    maze_wall_follower_if.master        mem,
    output logic                        done_o,
    output logic                        stuck_o,
    output logic [15:0]                 steps_o,
    output logic [2:0]                  state_o,
    output logic [1:0]                  dir_o
);
    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_MARK0 = 3'd1;
    localparam logic [2:0] S_PROBE = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_WALL  = 3'd4;
    localparam logic [2:0] S_MOVE  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_STUCK = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [5:0]  cur_r_q, cur_r_d, cur_c_q, cur_c_d;
    logic [1:0]  dir_q, dir_d, try_q, try_d;
    logic [2:0]  fails_q, fails_d;
    logic [15:0] steps_q, steps_d;
    logic [5:0]  last_r_q, last_r_d, last_c_q, last_c_d;

    logic [5:0]  cand_r, cand_c;
    logic        cand_ok, cand_border;
    logic        drive_en, oe_w, we_w;
    logic [5:0]  drive_r, drive_c;

    // Candidate neighbour; cand_ok is low when the step would leave the 6-bit grid.
    always_comb begin
        cand_r  = cur_r_q;
        cand_c  = cur_c_q;
        cand_ok = 1'b1;
        case (try_q)
            2'd0: begin cand_r = cur_r_q - 6'd1; cand_ok = (cur_r_q != 6'd0);  end
            2'd1: begin cand_c = cur_c_q + 6'd1; cand_ok = (cur_c_q != 6'd63); end
            2'd2: begin cand_r = cur_r_q + 6'd1; cand_ok = (cur_r_q != 6'd63); end
            default: begin cand_c = cur_c_q - 6'd1; cand_ok = (cur_c_q != 6'd0); end
        endcase
        cand_border = (cand_r == 6'd0) || (cand_r == 6'd63) ||
                      (cand_c == 6'd0) || (cand_c == 6'd63);
    end

    always_comb begin
        drive_en = 1'b0;
        drive_r  = cand_r;
        drive_c  = cand_c;
        oe_w     = 1'b0;
        we_w     = 1'b0;
        case (state_q)
            S_MARK0: begin drive_en = 1'b1; drive_r = cur_r_q; drive_c = cur_c_q; we_w = 1'b1; end
            S_PROBE: begin drive_en = cand_ok; oe_w = cand_ok; end
            S_MOVE:  begin drive_en = 1'b1; we_w = 1'b1; end
            default: ;
        endcase
        last_r_d = drive_en ? drive_r : last_r_q;
        last_c_d = drive_en ? drive_c : last_c_q;
    end

    // Address holds its last driven value whenever no access is in progress.
    assign mem.row = drive_en ? drive_r : last_r_q;
    assign mem.col = drive_en ? drive_c : last_c_q;
    assign mem.oe  = oe_w;
    assign mem.we  = we_w;

    always_comb begin
        state_d = state_q;
        cur_r_d = cur_r_q;
        cur_c_d = cur_c_q;
        dir_d   = dir_q;
        try_d   = try_q;
        fails_d = fails_q;
        steps_d = steps_q;
        case (state_q)
            S_INIT: begin
                cur_r_d = starting_row_i;
                cur_c_d = starting_col_i;
                dir_d   = 2'd0;
                state_d = S_MARK0;
            end
            S_MARK0: begin
                try_d   = dir_q + 2'd1;
                fails_d = 3'd0;
                state_d = S_PROBE;
            end
            S_PROBE: state_d = cand_ok ? S_EVAL : S_WALL;
            S_EVAL:  state_d = mem.maze_in ? S_WALL : S_MOVE;
            S_WALL: begin
                fails_d = fails_q + 3'd1;
                try_d   = try_q - 2'd1;
                state_d = (fails_d == 3'd4) ? S_STUCK : S_PROBE;
            end
            S_MOVE: begin
                cur_r_d = cand_r;
                cur_c_d = cand_c;
                dir_d   = try_q;
                if (steps_q != MAX_STEPS) steps_d = steps_q + 16'd1;
                if (cand_border) begin
                    state_d = S_DONE;
                end else if (steps_d == MAX_STEPS) begin
                    state_d = S_STUCK;
                end else begin
                    try_d   = try_q + 2'd1;
                    fails_d = 3'd0;
                    state_d = S_PROBE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            cur_r_q  <= 6'd0;
            cur_c_q  <= 6'd0;
            dir_q    <= 2'd0;
            try_q    <= 2'd0;
            fails_q  <= 3'd0;
            steps_q  <= 16'd0;
            last_r_q <= 6'd0;
            last_c_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            cur_r_q  <= cur_r_d;
            cur_c_q  <= cur_c_d;
            dir_q    <= dir_d;
            try_q    <= try_d;
            fails_q  <= fails_d;
            steps_q  <= steps_d;
            last_r_q <= last_r_d;
            last_c_q <= last_c_d;
        end
    end

    assign done_o  = (state_q == S_DONE);
    assign stuck_o = (state_q == S_STUCK);
    assign steps_o = steps_q;
    assign state_o = state_q;
    assign dir_o   = dir_q;
endmodule

// File: tb/tb_maze_wall_follower.sv
// Bench for maze_wall_follower: behavioural maze store plus a right-hand-rule walk model.
module tb_maze_wall_follower;
    localparam logic [15:0] MAX_STEPS = 16'd200;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  starting_row, starting_col;
    logic        done, stuck;
    logic [15:0] steps;
    logic [2:0]  state;
    logic [1:0]  dir;

    maze_wall_follower_if mif();

    maze_wall_follower #(.MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .rst(rst),
        .starting_row_i(starting_row), .starting_col_i(starting_col),
        .mem(mif),
        .done_o(done), .stuck_o(stuck), .steps_o(steps),
        .state_o(state), .dir_o(dir)
    );

    always #5 clk = ~clk;

    // Maze store: a cell marked during the current run reads as free (value 2'b10).
    bit walls [64][64];
    int mark_run [64][64];
    int run_id = 0;
    always @(posedge clk) begin
        if (mif.oe) mif.maze_in <= (mark_run[mif.row][mif.col] == run_id) ? 1'b0 : walls[mif.row][mif.col];
        if (mif.we) mark_run[mif.row][mif.col] <= run_id;
    end

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int exp_oe, exp_end, exp_steps;
    bit exp_done, exp_stuck;
    logic [1:0] exp_dir;
    int obs_oe, obs_end, obs_first_oe, obs_both;
    int checks = 0;
    int errors = 0;

    task automatic clear_maze();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) walls[r][c] = 1'b1;
    endtask

    task automatic open_cell(input int r, input int c);
        walls[r][c] = 1'b0;
    endtask

    // Walks the maze by the right-hand rule on plain integer coordinates.
    task automatic model_walk(input int sr, input int sc);
        int r, c, d, t, nr, nc, cyc;
        bit moved, fin;
        r = sr; c = sc; d = 0; cyc = 2; fin = 0;
        exp_q.delete();
        exp_q.push_back({r[5:0], c[5:0]});
        exp_oe = 0; exp_steps = 0; exp_done = 0; exp_stuck = 0;
        while (!fin) begin
            moved = 0;
            for (int k = 0; k < 4 && !moved; k++) begin
                t  = (d + 5 - k) % 4;
                nr = r + ((t == 2) ? 1 : (t == 0) ? -1 : 0);
                nc = c + ((t == 1) ? 1 : (t == 3) ? -1 : 0);
                if (nr < 0 || nr > 63 || nc < 0 || nc > 63) begin
                    cyc += 2;
                end else begin
                    exp_oe++;
                    cyc += 3;
                    if (!walls[nr][nc]) begin
                        moved = 1; r = nr; c = nc; d = t; exp_steps++;
                        exp_q.push_back({r[5:0], c[5:0]});
                    end
                end
            end
            if (!moved) begin exp_stuck = 1; fin = 1; end
            else if (r == 0 || r == 63 || c == 0 || c == 63) begin exp_done = 1; fin = 1; end
            else if (exp_steps == MAX_STEPS) begin exp_stuck = 1; fin = 1; end
        end
        exp_dir = d[1:0];
        exp_end = cyc + 1;
    endtask

    task automatic start_walk(input int sr, input int sc);
        rst = 1'b1;
        run_id++;
        starting_row = sr[5:0];
        starting_col = sc[5:0];
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycle 1 is INIT (the cycle reset is released in); observes from cycle 2 on.
    task automatic observe(input int budget);
        obs_q.delete(); obs_oe = 0; obs_both = 0; obs_end = 0; obs_first_oe = 0;
        for (int cyc = 2; cyc <= budget && obs_end == 0; cyc++) begin
            @(negedge clk);
            if (mif.we) obs_q.push_back({mif.row, mif.col});
            if (mif.oe) begin
                obs_oe++;
                if (obs_first_oe == 0) obs_first_oe = cyc;
            end
            if (mif.oe && mif.we) obs_both++;
            if (done || stuck) obs_end = cyc;
        end
    endtask

    function automatic int we_diffs();
        int n;
        n = (obs_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        starting_row = 6'd0;
        starting_col = 6'd0;
        #1;
        checks++; if ({mif.row, mif.col} !== 12'd0) begin errors++; $display("FAIL reset_addr got %h want 000", {mif.row, mif.col}); end
        checks++; if ({mif.oe, mif.we} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {mif.oe, mif.we}); end
        checks++; if ({done, stuck, steps} !== 18'd0) begin errors++; $display("FAIL reset_status got done=%b stuck=%b steps=%0d want 0 0 0", done, stuck, steps); end
        checks++; if ($isunknown(state)) begin errors++; $display("FAIL reset_state got %b want known", state); end
        @(negedge clk);
    endtask

    task automatic test_corridor();
        clear_maze(); open_cell(5, 1); open_cell(5, 0);
        model_walk(5, 1);
        start_walk(5, 1);
        observe(exp_end + 10);
        checks++; if (obs_end !== exp_end) begin errors++; $display("FAIL corridor_end_cycle got %0d want %0d", obs_end, exp_end); end
        checks++; if (obs_first_oe !== 3) begin errors++; $display("FAIL corridor_first_oe got %0d want 3", obs_first_oe); end
        checks++; if ({done, stuck} !== 2'b10 || steps !== 16'd1) begin errors++; $display("FAIL corridor_result got done=%b stuck=%b steps=%0d want 1 0 1", done, stuck, steps); end
        checks++; if (obs_q.size() !== 2 || obs_q[0] !== {6'd5, 6'd1} || obs_q[1] !== {6'd5, 6'd0}) begin errors++; $display("FAIL corridor_we got %0d marks want 2 at (5,1),(5,0)", obs_q.size()); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || {mif.row, mif.col} !== {6'd5, 6'd0} || {mif.oe, mif.we} !== 2'b00) begin errors++; $display("FAIL corridor_hold got done=%b addr=(%0d,%0d) strobes=%b want 1 (5,0) 00", done, mif.row, mif.col, {mif.oe, mif.we}); end
    endtask

    task automatic test_right_pref();
        clear_maze(); open_cell(10, 10); open_cell(9, 10);
        for (int c = 11; c < 64; c++) open_cell(10, c);
        model_walk(10, 10);
        start_walk(10, 10);
        observe(exp_end + 10);
        checks++; if (obs_q.size() < 2 || obs_q[1] !== {6'd10, 6'd11}) begin errors++; $display("FAIL right_pref_first_move got %h want %h", (obs_q.size() > 1) ? obs_q[1] : 12'hfff, {6'd10, 6'd11}); end
        checks++; if (dir !== 2'd1 || exp_dir !== 2'd1) begin errors++; $display("FAIL right_pref_dir got %0d want 1", dir); end
        checks++; if (done !== 1'b1 || steps !== 16'd53) begin errors++; $display("FAIL right_pref_result got done=%b steps=%0d want 1 53", done, steps); end
        checks++; if (we_diffs() !== 0) begin errors++; $display("FAIL right_pref_we got %0d diffs want 0", we_diffs()); end
    endtask

    task automatic build_dead_end();
        clear_maze();
        open_cell(10, 10); open_cell(10, 11); open_cell(10, 12);
        for (int r = 0; r < 10; r++) open_cell(r, 10);
    endtask

    task automatic test_dead_end();
        build_dead_end();
        model_walk(10, 10);
        start_walk(10, 10);
        observe(exp_end + 10);
        checks++; if (done !== 1'b1 || steps !== 16'd14) begin errors++; $display("FAIL dead_end_result got done=%b steps=%0d want 1 14", done, steps); end
        checks++; if (obs_end !== exp_end) begin errors++; $display("FAIL dead_end_end_cycle got %0d want %0d", obs_end, exp_end); end
        checks++; if (we_diffs() !== 0) begin errors++; $display("FAIL dead_end_we got %0d diffs want 0", we_diffs()); end
        checks++; if ({mif.row, mif.col} !== {6'd0, 6'd10}) begin errors++; $display("FAIL dead_end_addr got (%0d,%0d) want (0,10)", mif.row, mif.col); end
    endtask

    task automatic test_enclosed();
        clear_maze(); open_cell(20, 20);
        model_walk(20, 20);
        start_walk(20, 20);
        observe(exp_end + 10);
        checks++; if (obs_oe !== 4) begin errors++; $display("FAIL enclosed_oe got %0d want 4", obs_oe); end
        checks++; if ({done, stuck} !== 2'b01 || steps !== 16'd0) begin errors++; $display("FAIL enclosed_result got done=%b stuck=%b steps=%0d want 0 1 0", done, stuck, steps); end
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL enclosed_we got %0d marks want 1", obs_q.size()); end
        checks++; if (obs_end !== 15) begin errors++; $display("FAIL enclosed_end_cycle got %0d want 15", obs_end); end
    endtask

    task automatic test_border_start();
        clear_maze();
        for (int r = 0; r < 64; r++) open_cell(r, 5);
        model_walk(0, 5);
        start_walk(0, 5);
        observe(exp_end + 10);
        checks++; if (done !== 1'b1 || steps !== 16'd63) begin errors++; $display("FAIL border_result got done=%b steps=%0d want 1 63", done, steps); end
        checks++; if (obs_oe !== 127) begin errors++; $display("FAIL border_oe got %0d want 127", obs_oe); end
        checks++; if (obs_end !== exp_end) begin errors++; $display("FAIL border_end_cycle got %0d want %0d", obs_end, exp_end); end
        checks++; if ({mif.row, mif.col} !== {6'd63, 6'd5}) begin errors++; $display("FAIL border_addr got (%0d,%0d) want (63,5)", mif.row, mif.col); end
    endtask

    task automatic test_step_budget();
        clear_maze(); open_cell(20, 20); open_cell(20, 21); open_cell(21, 20); open_cell(21, 21);
        model_walk(20, 20);
        start_walk(20, 20);
        observe(exp_end + 10);
        checks++; if ({done, stuck} !== 2'b01 || steps !== MAX_STEPS) begin errors++; $display("FAIL budget_result got done=%b stuck=%b steps=%0d want 0 1 %0d", done, stuck, steps, MAX_STEPS); end
        checks++; if (obs_end !== exp_end) begin errors++; $display("FAIL budget_end_cycle got %0d want %0d", obs_end, exp_end); end
        repeat (3) @(negedge clk);
        checks++; if (steps !== MAX_STEPS || stuck !== 1'b1) begin errors++; $display("FAIL budget_hold got stuck=%b steps=%0d want 1 %0d", stuck, steps, MAX_STEPS); end
    endtask

    task automatic test_reset_mid_walk();
        int seen;
        build_dead_end();
        model_walk(10, 10);
        start_walk(10, 10);
        seen = 0;
        for (int i = 0; i < 30 && seen < 2; i++) begin
            @(negedge clk);
            if (mif.oe) seen++;
        end
        checks++; if (seen !== 2) begin errors++; $display("FAIL midreset_reach got %0d reads want 2", seen); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({mif.row, mif.col, mif.oe, mif.we} !== 14'd0) begin errors++; $display("FAIL midreset_port got %h want 0", {mif.row, mif.col, mif.oe, mif.we}); end
        checks++; if ({done, stuck, steps} !== 18'd0) begin errors++; $display("FAIL midreset_status got %h want 0", {done, stuck, steps}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        observe(exp_end + 10);
        checks++; if (obs_first_oe !== 3) begin errors++; $display("FAIL midreset_first_oe got %0d want 3", obs_first_oe); end
        checks++; if (obs_end !== exp_end || steps !== 16'd14 || done !== 1'b1) begin errors++; $display("FAIL midreset_rerun got end=%0d steps=%0d done=%b want %0d 14 1", obs_end, steps, done, exp_end); end
        checks++; if (we_diffs() !== 0) begin errors++; $display("FAIL midreset_we got %0d diffs want 0", we_diffs()); end
    endtask

    task automatic test_random();
        int sr, sc;
        for (int it = 0; it < 10; it++) begin
            clear_maze();
            sr = $urandom_range(2, 61);
            sc = $urandom_range(1, 6);
            for (int r = sr - 6; r <= sr + 6; r++)
                for (int c = 0; c <= 12; c++)
                    if (r >= 0 && r < 64) walls[r][c] = ($urandom_range(0, 99) < 35);
            open_cell(sr, sc);
            model_walk(sr, sc);
            start_walk(sr, sc);
            observe(exp_end + 10);
            checks++; if (obs_end !== exp_end) begin errors++; $display("FAIL random%0d_end_cycle got %0d want %0d", it, obs_end, exp_end); end
            checks++; if (done !== exp_done || stuck !== exp_stuck) begin errors++; $display("FAIL random%0d_outcome got done=%b stuck=%b want %b %b", it, done, stuck, exp_done, exp_stuck); end
            checks++; if (steps !== exp_steps[15:0]) begin errors++; $display("FAIL random%0d_steps got %0d want %0d", it, steps, exp_steps); end
            checks++; if (obs_oe !== exp_oe || obs_both !== 0) begin errors++; $display("FAIL random%0d_reads got oe=%0d overlap=%0d want %0d 0", it, obs_oe, obs_both, exp_oe); end
            checks++; if (we_diffs() !== 0) begin errors++; $display("FAIL random%0d_we got %0d diffs want 0", it, we_diffs()); end
            checks++; if (dir !== exp_dir) begin errors++; $display("FAIL random%0d_dir got %0d want %0d", it, dir, exp_dir); end
        end
    endtask

    initial begin
        test_reset();
        test_corridor();
        test_right_pref();
        test_dead_end();
        test_enclosed();
        test_border_start();
        test_step_budget();
        test_reset_mid_walk();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maze_wall_follower.md
# maze_wall_follower

Right-hand-rule maze solver: the initiator side of the maze cell-memory port. It drives row/col/oe/we into the 64x64 maze store and consumes the registered 1-bit cell value. It walks from the starting cell to any free border cell, marking each cell entered as path, and raises `done` on success or `stuck` if the start cell is enclosed.

## Interface
- MAX_STEPS, 16'hFFFF: step budget; `stuck` is raised when it is exhausted.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- starting_row  in  6  row of the start cell; sampled in INIT.
- starting_col  in  6  column of the start cell; sampled in INIT.
- row  out  6  row of the addressed cell.
- col  out  6  column of the addressed cell.
- oe  out  1  read request; maze store latches `cell[row][col]` at this edge.
- we  out  1  path-mark write of `cell[row][col]`.
- maze_in  in  1  cell bit 0 (1 = wall, 0 = free); valid the cycle after `oe`.
- done  out  1  exit reached; sticky until reset.
- stuck  out  1  no progress possible or step budget exhausted; sticky until reset.
- steps  out  16  number of moves made; saturates at MAX_STEPS.

## Operation
- Internal registers:
  - `cur_r`, `cur_c` (6 bits each): current position.
  - `dir` (2 bits): 0 = up (r-1), 1 = right (c+1), 2 = down (r+1), 3 = left (c-1).
  - `try_d` (2 bits): direction being probed.
  - `fails` (3 bits): consecutive walls in the current probe round.
- States:
  - INIT: load `cur` from the starting inputs; `dir` = 0.
  - MARK0: `we` = 1 at the start cell; then `try_d` = `dir` + 1 (turn right first), `fails` = 0.
  - PROBE: compute the candidate cell `cur` + step(`try_d`).
    - Candidate outside 0..63 (underflow or overflow of the 6-bit index): treat as a wall with no read. Go to WALL; `oe` stays 0.
    - Otherwise drive `row`/`col` = candidate with `oe` = 1, then go to EVAL.
  - EVAL: sample `maze_in`. 0 goes to MOVE; 1 goes to WALL.
  - WALL: `fails` + 1 and `try_d` − 1 (mod 4, left rotation). If `fails` reaches 4, go to STUCK; else go to PROBE.
  - MOVE: `cur` = candidate, `dir` = `try_d`, `steps` + 1 (saturating). Drive `row`/`col` = candidate with `we` = 1.
    - Candidate on the border (row or col equal to 0 or 63): go to DONE.
    - `steps` reaches MAX_STEPS: go to STUCK.
    - Otherwise set `try_d` = `try_d` + 1, `fails` = 0, and go to PROBE.
  - DONE and STUCK: terminal. All strobes are 0, and `row`/`col` hold the last value.
- The start cell never counts as an exit, even when it is on the border.
- Previously marked cells (value 2'b10) read as free. Revisiting is allowed, and the wall follower still terminates on any simply connected maze.
- Turn order per round is right, straight, left, back. Four walls in one round means the start cell is enclosed.

## Timing
- Reset values: `row` = 0, `col` = 0, `oe` = 0, `we` = 0, `done` = 0, `stuck` = 0, `steps` = 0; state = INIT.
- Reset asserted mid-walk aborts immediately. All outputs take their reset values asynchronously; the walk restarts at INIT after release.
- `oe` and `we` are never both 1, and each is high for exactly one cycle per access.
- Read latency: `oe` is high in PROBE at cycle N; `maze_in` is sampled at the end of EVAL, cycle N+1.
- An out-of-grid probe costs 1 cycle (PROBE) plus 1 cycle (WALL).
- In-grid costs:
  - In-grid probe hitting a wall: 3 cycles (PROBE, EVAL, WALL).
  - In-grid probe that moves: 3 cycles (PROBE, EVAL, MOVE).
- Startup: INIT and MARK0 take 2 cycles, so the first `oe` is in cycle 3 after reset release.
- `done`/`stuck` rise in the cycle after MOVE/WALL, and `steps` is final at that point.

## Test plan
- Straight corridor: start (5,1), free cells (5,1) through (5,0), all else wall.
  - Required response: one left move.
  - `done` = 1, `steps` = 1.
  - `we` pulses at (5,1) and then at (5,0).
- Right preference: start (10,10), dir up, with (10,11) and (9,10) both free.
  - Required response: the first MOVE goes to (10,11); `dir` = 1.
- Dead end: corridor (10,10) to (10,12), walls around it, exit at (9,10) to (0,10).
  - Required response: the walker U-turns at (10,12) and returns.
  - `done` = 1 when the walker reaches (0,10).
  - `steps` matches a hand count of the walk.
- Enclosed start (20,20) with all neighbours walls.
  - Required response: exactly 4 `oe` pulses, then `stuck` = 1.
  - `steps` = 0, and no `we` after MARK0.
- Border start (0,5), with (1,5) free and a path to (63,5).
  - Required response: no immediate `done`; the probe upward performs no read.
  - `done` = 1 only at (63,5).
- Reset mid-walk: assert `rst` during EVAL.
  - Required response: outputs reset asynchronously.
  - After release, the first `oe` is in cycle 3, and the walk repeats identically.
